// File: rtl/hh2_merge_arbiter.sv
// Two-input token merge arbiter with a one-entry output slot.
// Burst-limited round-robin between In1 and In2; idle arbitration favours the input not served last.
module hh2_merge_arbiter #(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] In1_DATA,
  input  logic             In1_SEND,
  input  logic [15:0]      In1_COUNT,
  output logic             In1_ACK,
  input  logic [WIDTH-1:0] In2_DATA,
  input  logic             In2_SEND,
  input  logic [15:0]      In2_COUNT,
  output logic             In2_ACK,
  output logic [WIDTH-1:0] Out1_DATA,
  output logic             Out1_SEND,
  input  logic             Out1_RDY,
  input  logic             Out1_ACK,
  output logic [15:0]      Out1_COUNT,
  output logic             Out1_SRC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_t;

  localparam logic [7:0] BURST_C = 8'(BURST);

  state_t           state_q;
  logic [7:0]       cnt_q;
  logic             last_q;    // 0 = In1 served last, 1 = In2 served last
  logic             valid_q, valid_d;
  logic             src_q, src_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic       slot_free;
  logic       gnt1, gnt2;
  logic       ack1, ack2;
  logic [7:0] cnt_inc;
  logic       burst_done;
  logic       unused_inputs;

  assign unused_inputs = ^{In1_COUNT, In2_COUNT, Out1_ACK};

  assign slot_free  = ~valid_q | Out1_RDY;
  assign cnt_inc    = cnt_q + 8'd1;
  assign burst_done = (cnt_inc >= BURST_C);

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    unique case (state_q)
      G1:      gnt1 = 1'b1;
      G2:      gnt2 = 1'b1;
      default: begin
        if (In1_SEND && In2_SEND) begin
          gnt1 = last_q;
          gnt2 = ~last_q;
        end else begin
          gnt1 = In1_SEND;
          gnt2 = In2_SEND;
        end
      end
    endcase
  end

  // Gated by RESET so no handshake can complete while the block is held in reset.
  assign ack1 = RESET & gnt1 & In1_SEND & slot_free;
  assign ack2 = RESET & gnt2 & In2_SEND & slot_free;

  assign In1_ACK    = ack1;
  assign In2_ACK    = ack2;
  assign Out1_SEND  = valid_q & Out1_RDY;
  assign Out1_DATA  = data_q;
  assign Out1_SRC   = src_q;
  assign Out1_COUNT = 16'h1;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    if (ack1) begin
      valid_d = 1'b1;
      data_d  = In1_DATA;
      src_d   = 1'b0;
    end else if (ack2) begin
      valid_d = 1'b1;
      data_d  = In2_DATA;
      src_d   = 1'b1;
    end else if (Out1_RDY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  // A stalled slot freezes arbitration entirely.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      last_q  <= 1'b1;
    end else if (slot_free) begin
      unique case (state_q)
        IDLE: begin
          if (ack1) begin
            state_q <= G1;
            cnt_q   <= 8'd1;
            last_q  <= 1'b0;
          end else if (ack2) begin
            state_q <= G2;
            cnt_q   <= 8'd1;
            last_q  <= 1'b1;
          end
        end
        G1: begin
          if (In1_SEND) begin
            last_q <= 1'b0;
            if (burst_done) begin
              cnt_q <= 8'd0;
              if (In2_SEND) state_q <= G2;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else if (In2_SEND) begin
            state_q <= G2;
            cnt_q   <= 8'd0;
          end else begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end
        end
        G2: begin
          if (In2_SEND) begin
            last_q <= 1'b1;
            if (burst_done) begin
              cnt_q <= 8'd0;
              if (In1_SEND) state_q <= G1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else if (In1_SEND) begin
            state_q <= G1;
            cnt_q   <= 8'd0;
          end else begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hh2_merge_arbiter.sv
// Randomised scoreboard bench for hh2_merge_arbiter with a rule-level arbitration model.
// Stimulus pushes expected {src,data} tokens; a negedge monitor pops them on Out1_SEND.
module tb_hh2_merge_arbiter;
  localparam int W     = 16;
  localparam int BURST = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [W-1:0] In1_DATA, In2_DATA, Out1_DATA;
  logic         In1_SEND, In2_SEND, In1_ACK, In2_ACK;
  logic [15:0]  In1_COUNT, In2_COUNT, Out1_COUNT;
  logic         Out1_SEND, Out1_RDY, Out1_ACK, Out1_SRC;

  hh2_merge_arbiter #(.WIDTH(W), .BURST(BURST)) dut (
    .CLK(CLK), .RESET(RESET),
    .In1_DATA(In1_DATA), .In1_SEND(In1_SEND), .In1_COUNT(In1_COUNT), .In1_ACK(In1_ACK),
    .In2_DATA(In2_DATA), .In2_SEND(In2_SEND), .In2_COUNT(In2_COUNT), .In2_ACK(In2_ACK),
    .Out1_DATA(Out1_DATA), .Out1_SEND(Out1_SEND), .Out1_RDY(Out1_RDY),
    .Out1_ACK(Out1_ACK), .Out1_COUNT(Out1_COUNT), .Out1_SRC(Out1_SRC)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] tok1, tok2;

  // Reference model: owner 0=none,1=In1,2=In2; run = tokens taken in current grant.
  int owner = 0;
  int run   = 0;
  int last  = 2;
  bit m_valid = 0;
  bit e1 = 0;
  bit e2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    bit s1, s2, rdy, free, mine, other;
    int cand;
    if (!RESET) begin
      check("rst_ack1", In1_ACK, 0);
      check("rst_ack2", In2_ACK, 0);
      check("rst_send", Out1_SEND, 0);
      check("rst_data", Out1_DATA, 0);
      check("rst_src", Out1_SRC, 0);
      owner = 0; run = 0; last = 2; m_valid = 0; e1 = 0; e2 = 0;
      exp_q.delete();
    end else begin
      s1 = In1_SEND; s2 = In2_SEND; rdy = Out1_RDY;
      free = !m_valid || rdy;
      if (owner != 0) cand = owner;
      else if (s1 && s2) cand = (last == 2) ? 1 : 2;
      else if (s1) cand = 1;
      else if (s2) cand = 2;
      else cand = 0;
      e1 = free && s1 && (cand == 1);
      e2 = free && s2 && (cand == 2);
      check("in1_ack", In1_ACK, e1);
      check("in2_ack", In2_ACK, e2);
      check("out_send", Out1_SEND, m_valid && rdy);
      if (free) begin
        if (owner == 0) begin
          if (cand != 0) begin owner = cand; run = 1; end
        end else begin
          mine  = (owner == 1) ? s1 : s2;
          other = (owner == 1) ? s2 : s1;
          if (mine) begin
            run++;
            if (run >= BURST) begin
              run = 0;
              if (other) owner = 3 - owner;
            end
          end else if (other) begin
            owner = 3 - owner; run = 0;
          end else begin
            owner = 0; run = 0;
          end
        end
      end
      if (e1) last = 1;
      if (e2) last = 2;
      if (e1 || e2) m_valid = 1;
      else if (rdy) m_valid = 0;
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (exp_q.size() > 0) check("out_token", {Out1_SRC, Out1_DATA}, exp_q[0]);
      if (Out1_SEND) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_extra: got token %0h, expected none at %0t", {Out1_SRC, Out1_DATA}, $time);
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle(input int p1, input int p2, input int prdy);
    @(posedge CLK);
    #1;
    if (e1) begin exp_q.push_back({1'b0, tok1}); tok1 = W'($urandom); end
    if (e2) begin exp_q.push_back({1'b1, tok2}); tok2 = W'($urandom); end
    In1_SEND = ($urandom_range(99) < p1);
    In2_SEND = ($urandom_range(99) < p2);
    Out1_RDY = ($urandom_range(99) < prdy);
    In1_DATA = tok1;
    In2_DATA = tok2;
  endtask

  initial begin
    In1_SEND = 0; In2_SEND = 0; Out1_RDY = 0; Out1_ACK = 0;
    In1_COUNT = 16'h0; In2_COUNT = 16'h0;
    tok1 = 16'h0011; tok2 = 16'h2222;
    In1_DATA = tok1; In2_DATA = tok2;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1; In1_SEND = 1; Out1_RDY = 1;
    check("out_count", Out1_COUNT, 16'h1);
    for (int i = 0; i < 6; i++) cycle(100, 0, 100);
    for (int i = 0; i < 40; i++) cycle(100, 100, 100);
    for (int i = 0; i < 12; i++) cycle(100, 0, 100);
    for (int i = 0; i < 20; i++) cycle(100, 100, 100);
    for (int i = 0; i < 5; i++) cycle(100, 100, 0);
    for (int i = 0; i < 5; i++) cycle(100, 100, 100);
    for (int i = 0; i < 1500; i++) cycle(70, 60, 75);
    for (int i = 0; i < 800; i++) cycle(30, 30, 50);
    // Fresh start, then reset during the second token of the first burst.
    @(posedge CLK); #2; RESET = 0;
    @(posedge CLK); #1; RESET = 1; In1_SEND = 1; In2_SEND = 1; Out1_RDY = 1;
    cycle(100, 100, 100);
    #1; RESET = 0;
    repeat (2) @(posedge CLK);
    #1; RESET = 1;
    for (int i = 0; i < 20; i++) cycle(100, 100, 100);
    for (int i = 0; i < 6; i++) cycle(0, 0, 100);
    check("drain_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
